// File: rtl/pipeline_register_if.sv
// Bus bundle for pipeline_register: select, write enable, write data, read data.
interface pipeline_register_if #(
  parameter int WIDTH = 32
);
  logic             sel;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  // Requester side: drives select/write, observes read data.
  modport master (
    output sel,
    output wr,
    output wdata,
    input  rdata
  );

  // Register side: observes select/write, drives read data.
  modport slave (
    input  sel,
    input  wr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/pipeline_register.sv
// Parameterised holding/pipeline register. Writes enter stage 0 and shift one
// stage per enabled edge; the last stage is visible on rdata while selected.
module pipeline_register #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                reset,
  pipeline_register_if.slave bus
);

  generate
    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
      $error("pipeline_register: STAGES must be in 1..16");
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic             en;

  assign en = bus.sel & bus.wr;

  // Next-state: capture into stage 0 and shift the rest when enabled, else hold.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = bus.wdata;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset forces every stage to RESET_VAL without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // Read port: last stage when selected, zero otherwise; never touches state.
  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      bus.rdata = stage_q[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench: one single-stage instance and one three-stage instance
// sharing clock and reset, with hand-computed expected read values.
module tb_pipeline_register;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  pipeline_register_if #(.WIDTH(32)) if1 ();
  pipeline_register_if #(.WIDTH(32)) if3 ();

  pipeline_register #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  pipeline_register #(.WIDTH(32), .STAGES(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset     = 1'b0;
    if1.sel   = 1'b1;
    if1.wr    = 1'b0;
    if1.wdata = '0;
    if3.sel   = 1'b1;
    if3.wr    = 1'b0;
    if3.wdata = '0;

    // Reset asserted from time zero, checked before any clock edge.
    #1;
    check("rst1_t0", if1.rdata, 32'h0);
    check("rst3_t0", if3.rdata, 32'h0);

    // Release between edges.
    tick();
    #3;
    reset = 1'b1;
    tick();
    check("rst1_released", if1.rdata, 32'h0);

    // Single write.
    if1.wdata = 32'h0000_1234;
    if1.wr    = 1'b1;
    tick();
    if1.wr    = 1'b0;
    check("single_wr", if1.rdata, 32'h0000_1234);
    tick();
    check("single_hold", if1.rdata, 32'h0000_1234);

    // Three-cycle write with data changing on the second cycle.
    if1.wr    = 1'b1;
    if1.wdata = 32'h0000_5678;
    tick();
    check("multi_c1", if1.rdata, 32'h0000_5678);
    if1.wdata = 32'h0000_CDEF;
    tick();
    tick();
    if1.wr    = 1'b0;
    check("multi_cdef", if1.rdata, 32'h0000_CDEF);

    if1.wr    = 1'b1;
    if1.wdata = 32'h0000_1234;
    tick();
    if1.wdata = 32'h0000_BEEF;
    tick();
    tick();
    if1.wr    = 1'b0;
    check("multi_beef", if1.rdata, 32'h0000_BEEF);

    // Deselected write must be ignored and read back as zero.
    if1.sel   = 1'b0;
    if1.wr    = 1'b1;
    if1.wdata = 32'h0000_2424;
    #1;
    check("desel_rd0", if1.rdata, 32'h0);
    tick();
    check("desel_rd1", if1.rdata, 32'h0);
    tick();
    check("desel_rd2", if1.rdata, 32'h0);
    if1.wr    = 1'b0;
    if1.sel   = 1'b1;
    #1;
    check("resel_beef", if1.rdata, 32'h0000_BEEF);

    // Three-stage depth: A,B,C,D on consecutive enabled edges.
    if3.wr    = 1'b1;
    if3.wdata = 32'hA;
    tick();
    check("p3_e1", if3.rdata, 32'h0);
    if3.wdata = 32'hB;
    tick();
    check("p3_e2", if3.rdata, 32'h0);
    if3.wdata = 32'hC;
    tick();
    check("p3_e3", if3.rdata, 32'hA);
    if3.wdata = 32'hD;
    tick();
    check("p3_e4", if3.rdata, 32'hB);
    if3.wr    = 1'b0;
    if3.wdata = 32'hF;
    tick();
    check("p3_hold1", if3.rdata, 32'hB);
    tick();
    check("p3_hold2", if3.rdata, 32'hB);
    if3.sel = 1'b0;
    #1;
    check("p3_desel", if3.rdata, 32'h0);
    if3.sel = 1'b1;
    #1;
    check("p3_resel", if3.rdata, 32'hB);
    // One more enabled edge shifts C to the output.
    if3.wr = 1'b1;
    if3.wdata = 32'hE;
    tick();
    if3.wr = 1'b0;
    check("p3_shift_c", if3.rdata, 32'hC);

    // Reset mid-operation while writes are pending.
    if1.wr    = 1'b1;
    if1.wdata = 32'h0000_5555;
    if3.wr    = 1'b1;
    if3.wdata = 32'h0000_7777;
    #2;
    reset = 1'b0;
    #1;
    check("midrst1_async", if1.rdata, 32'h0);
    check("midrst3_async", if3.rdata, 32'h0);
    tick();
    check("midrst1_held", if1.rdata, 32'h0);
    check("midrst3_held", if3.rdata, 32'h0);
    tick();
    check("midrst1_held2", if1.rdata, 32'h0);

    // Release between edges; next edge captures again.
    #3;
    reset = 1'b1;
    #1;
    check("rel1_before_edge", if1.rdata, 32'h0);
    tick();
    if1.wr = 1'b0;
    if3.wr = 1'b0;
    check("rel1_capture", if1.rdata, 32'h0000_5555);
    check("rel3_capture", if3.rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
